// File: rtl/guess_entry.sv
// Bit-serial lock-guess entry from debounced zero/one/enter/clear buttons, MSB first.
// Optional idle timeout on a partial entry is enabled with GUESS_ENTRY_TIMEOUT_EN.
module guess_entry #(
  parameter int WIDTH          = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_zero,
  input  logic                       btn_one,
  input  logic                       btn_enter,
  input  logic                       btn_clear,
  output logic [WIDTH-1:0]           guess,
  output logic                       done,
  output logic                       entry_err,
  output logic [$clog2(WIDTH+1)-1:0] digit_count
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ENTRY, FULL, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  guess_q, guess_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Button vector order: {clear, enter, one, zero}
  logic [3:0] btn, prev_q, armed_q, armed_d, press;
  logic       digit_ok, digit_bit, timeout;

  assign btn = {btn_clear, btn_enter, btn_one, btn_zero};

  // A button must be seen low after reset before its rising edge counts, so a
  // button held through reset release produces no event.
  assign armed_d   = armed_q | ~btn;
  assign press     = btn & ~prev_q & armed_q;
  assign digit_ok  = press[0] ^ press[1];
  assign digit_bit = press[1];

`ifdef GUESS_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] idle_q, idle_d;

  assign timeout = ((state_q == ENTRY) || (state_q == FULL)) && (press == 4'b0000) &&
                   (idle_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_d = '0;
    if ((press == 4'b0000) && (state_d == state_q) &&
        ((state_q == ENTRY) || (state_q == FULL))) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  // Feature compiled out: the comparison is constant false.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    guess_d = guess_q;
    count_d = count_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      DONE: begin
        // Presses sampled in this cycle are dropped; guess stays for the comparator.
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        if (press[3]) begin
          state_d = IDLE;
          guess_d = '0;
          count_d = '0;
        end else if (press[2]) begin
          if (state_q == FULL) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
          end
        end else if (timeout) begin
          state_d = IDLE;
          guess_d = '0;
          count_d = '0;
          err_d   = 1'b1;
        end else if (digit_ok && (state_q != FULL)) begin
          if (state_q == IDLE) begin
            guess_d = {{(WIDTH-1){1'b0}}, digit_bit};
          end else begin
            guess_d = {guess_q[WIDTH-2:0], digit_bit};
          end
          count_d = count_q + 1'b1;
          state_d = (count_q == CNT_W'(WIDTH - 1)) ? FULL : ENTRY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      guess_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      prev_q  <= '0;
      armed_q <= '0;
    end else begin
      state_q <= state_d;
      guess_q <= guess_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
      prev_q  <= btn;
      armed_q <= armed_d;
    end
  end

  assign guess       = guess_q;
  assign done        = done_q;
  assign entry_err   = err_q;
  assign digit_count = count_q;

endmodule

// File: tb/tb_guess_entry.sv
// Self-checking bench for guess_entry: directed scenarios plus random button
// levels compared every cycle against a behavioural model of the entry rules.
module tb_guess_entry;

  localparam int W = 5;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bz = 1'b0, bo = 1'b0, be = 1'b0, bc = 1'b0;
  logic [W-1:0]           guess;
  logic                   done;
  logic                   entry_err;
  logic [$clog2(W+1)-1:0] digit_count;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int         m_count;
  int         m_idle;
  logic [W-1:0] m_val;
  bit         m_in_done, m_done, m_err;
  bit         m_last[4];
  bit         m_seen[4];

  guess_entry #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .btn_zero(bz), .btn_one(bo), .btn_enter(be), .btn_clear(bc),
    .guess(guess), .done(done), .entry_err(entry_err), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_idle = 0; m_val = '0;
    m_in_done = 0; m_done = 0; m_err = 0;
    for (int i = 0; i < 4; i++) begin
      m_last[i] = 0;
      m_seen[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit b[4];
    bit p[4];
    bit any, tmo;
    b = '{bz, bo, be, bc};
    for (int i = 0; i < 4; i++) p[i] = b[i] && !m_last[i] && m_seen[i];
    for (int i = 0; i < 4; i++) begin
      m_last[i] = b[i];
      if (!b[i]) m_seen[i] = 1;
    end
    any = p[0] | p[1] | p[2] | p[3];
    m_done = 0; m_err = 0; tmo = 0;
`ifdef GUESS_ENTRY_TIMEOUT_EN
    if (!m_in_done && m_count > 0 && !any) begin
      m_idle++;
      tmo = (m_idle == T);
    end else begin
      m_idle = 0;
    end
`endif
    if (m_in_done) begin
      m_in_done = 0;
      m_count = 0;
    end else if (p[3]) begin
      m_count = 0; m_val = '0;
    end else if (p[2]) begin
      if (m_count == W) begin
        m_in_done = 1; m_done = 1;
      end else begin
        m_err = 1;
      end
    end else if (tmo) begin
      m_count = 0; m_val = '0; m_err = 1; m_idle = 0;
    end else if ((p[0] != p[1]) && m_count < W) begin
      if (m_count == 0) m_val = W'(p[1]);
      else m_val = {m_val[W-2:0], p[1]};
      m_count++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_guess"}, int'(guess), int'(m_val));
    chk({tag, "_count"}, int'(digit_count), m_count);
    chk({tag, "_done"}, int'(done), int'(m_done));
    chk({tag, "_err"}, int'(entry_err), int'(m_err));
  endtask

  task automatic step(input bit z, input bit o, input bit e, input bit c);
    bz = z; bo = o; be = e; bc = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic tap(input int d);
    step(d == 0, d == 1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_guess", int'(guess), 0);
    chk("rst_count", int'(digit_count), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(entry_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("init");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Full entry 1,0,1,1,0 then enter
    tap(1); tap(0); tap(1); tap(1); tap(0);
    chk("full_count", int'(digit_count), 5);
    chk("full_guess", int'(guess), 5'b10110);
    step(0, 0, 1, 0);
    chk("submit_done", int'(done), 1);
    step(0, 0, 0, 0);
    chk("after_done", int'(done), 0);
    chk("after_count", int'(digit_count), 0);
    chk("after_guess", int'(guess), 5'b10110);

    // Early enter is an error; entry then continues
    tap(1); tap(1); tap(0);
    step(0, 0, 1, 0);
    chk("early_err", int'(entry_err), 1);
    chk("early_done", int'(done), 0);
    chk("early_count", int'(digit_count), 3);
    step(0, 0, 0, 0);
    chk("early_err_fall", int'(entry_err), 0);
    tap(0); tap(1);
    step(0, 0, 1, 0);
    chk("second_guess", int'(guess), 5'b11001);
    chk("second_done", int'(done), 1);
    step(0, 0, 0, 0);

    // Sixth digit ignored when full; press during DONE dropped
    tap(0); tap(0); tap(0); tap(0); tap(1);
    tap(1);
    chk("sixth_guess", int'(guess), 5'b00001);
    chk("sixth_count", int'(digit_count), 5);
    step(0, 0, 1, 0);
    chk("sixth_done", int'(done), 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("drop_count", int'(digit_count), 0);
    chk("drop_guess", int'(guess), 5'b00001);

    // Held button counts once; clear mid-entry; async reset mid-entry
    repeat (20) step(0, 1, 0, 0);
    chk("hold_count", int'(digit_count), 1);
    step(0, 0, 0, 0);
    tap(0);
    step(0, 0, 0, 1);
    chk("clear_guess", int'(guess), 0);
    chk("clear_count", int'(digit_count), 0);
    step(0, 0, 0, 0);
    tap(1); tap(1); tap(0);
    async_reset();
    step(0, 0, 0, 0);

    // Simultaneous zero/one ignored; clear beats enter when full
    tap(1);
    step(1, 1, 0, 0);
    chk("both_count", int'(digit_count), 1);
    chk("both_guess", int'(guess), 1);
    step(0, 0, 0, 0);
    tap(0); tap(1); tap(0); tap(1);
    chk("pre_ce_count", int'(digit_count), 5);
    step(0, 0, 1, 1);
    chk("ce_done", int'(done), 0);
    chk("ce_count", int'(digit_count), 0);
    chk("ce_guess", int'(guess), 0);
    step(0, 0, 0, 0);

    // Idle partial entry
    tap(1); tap(0);
    repeat (100) step(0, 0, 0, 0);
`ifdef GUESS_ENTRY_TIMEOUT_EN
    chk("idle_count", int'(digit_count), 0);
`else
    chk("idle_count", int'(digit_count), 2);
`endif

    // Random button levels with occasional reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/guess_entry.md
Name: guess_entry

Overview:
Collects a lock guess one bit at a time from four debounced push-button levels: zero, one, enter and clear. Once exactly WIDTH bits have been entered and enter is pressed, it presents a stable guess and pulses done. It sits directly upstream of the password comparator, driving that comparator's guess and done inputs. It also gives the user-interface logic an entry-error indication and a digit count.

Parameters:
WIDTH, 5, number of bits in a guess; must be ≥ 2 and must match the comparator's password width.
TIMEOUT_CYCLES, 1000, number of idle clock cycles before a partial entry is discarded; used only with GUESS_ENTRY_TIMEOUT_EN; must be ≥ 2.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
btn_zero  input  1  debounced level, synchronous to clk; a press enters bit 0.
btn_one  input  1  debounced level, synchronous to clk; a press enters bit 1.
btn_enter  input  1  debounced level; a press submits the guess.
btn_clear  input  1  debounced level; a press discards the partial entry.
guess  output  WIDTH  registered guess, MSB entered first.
done  output  1  registered one-cycle pulse; guess is valid while done is high.
entry_err  output  1  registered one-cycle pulse on an invalid submit (or on timeout, see Optional Feature).
digit_count  output  $clog2(WIDTH+1)  number of bits currently entered, 0..WIDTH.

Behaviour:
- Reset (asynchronous, rst=1):
  - guess=0, done=0, entry_err=0, digit_count=0.
  - state=IDLE; all edge-detect registers cleared.
  - Reset mid-entry discards the partial guess; no done is produced.
- Edge detection:
  - Each button has a previous-value flop; press = btn & ~btn_prev.
  - A held button counts once; a button already high when rst deasserts produces no event until it is released and pressed again.
- Event priority within one cycle: clear > enter > digit.
  - btn_zero and btn_one pressed in the same cycle: both ignored, no state change.
- States:
  - IDLE: digit_count=0.
  - ENTRY: 1 ≤ digit_count < WIDTH.
  - FULL: digit_count=WIDTH.
  - DONE: lasts one cycle, done=1.
- Digit press, applied on the same clock edge where the press is first sampled:
  - From IDLE: guess <= {0…0, bit}; digit_count=1; go to ENTRY (or FULL if WIDTH=1, which is disallowed).
  - From ENTRY: guess <= {guess[WIDTH-2:0], bit}; digit_count+1; go to FULL when the count reaches WIDTH.
  - In FULL: ignored; no error, no change.
- Enter press:
  - In FULL: go to DONE; done=1 on the following cycle for exactly one cycle; guess is held unchanged.
  - In IDLE or ENTRY: entry_err=1 for one cycle; guess and digit_count are unchanged.
- DONE → IDLE after one cycle:
  - digit_count=0.
  - guess keeps the submitted value until the next digit press, so the comparator still sees it after done falls.
  - Every button press sampled during the DONE cycle is dropped.
- Clear press in any state except DONE: guess=0, digit_count=0, go to IDLE; no pulse.
- done and entry_err are never high in the same cycle.

Optional Feature:
GUESS_ENTRY_TIMEOUT_EN
- Defined:
  - An idle counter runs in ENTRY and FULL; it resets to 0 on any accepted or ignored button press and on every state change.
  - When the counter reaches TIMEOUT_CYCLES-1: guess=0, digit_count=0, go to IDLE, and entry_err pulses for one cycle.
  - A clear or enter press in the same cycle as the timeout takes priority over the timeout.
- Not defined: no counter exists; a partial entry is held indefinitely, and entry_err pulses only on an invalid enter.

Test Plan:
- WIDTH=5; press 1,0,1,1,0, then enter → guess=5'b10110, digit_count=5 before enter, done high for exactly 1 cycle, then digit_count=0 with guess still 5'b10110.
- Press 1,1,0, then enter → entry_err pulses for 1 cycle, done stays 0, digit_count stays 3; press 0,1, then enter → guess=5'b11001, done pulses.
- Press 5 digits 0,0,0,0,1, then a sixth digit 1 → guess stays 5'b00001, digit_count stays 5; enter → done pulses.
- Hold btn_one high for 20 cycles → digit_count=1; press clear mid-entry → guess=0, digit_count=0; assert rst after 3 digits → all outputs 0 immediately, with no clock edge needed.
- btn_zero and btn_one rise in the same cycle → no change; enter and clear rise in the same cycle while FULL → clear wins, and done stays 0.
- With GUESS_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16: 2 digits, then idle → entry_err pulses at idle cycle 16 and digit_count=0. Without the macro, the same stimulus leaves digit_count=2 after 100 cycles.
